// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory port, with illegal-instruction trap and instret.
module riscv_multicycle_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func_3,
    input  logic [6:0]       func_7,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALRT, S_JALRL,
        S_LUI, S_AUIPC, S_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       legal_c, mem_done_c, retire_c;
    logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c, adr_src_c, illegal_c;
    logic [1:0] src_a_c, src_b_c, result_src_c;
    logic [2:0] imm_src_c, alu_ctl_c, alu_func_c;

    always_comb begin
        legal_c = 1'b0;
        case (opcode)
            OP_R:    legal_c = (func_3 != 3'b001) && (func_3 != 3'b101) &&
                               ((func_7 == 7'b0000000) ||
                                (func_7 == 7'b0100000 && func_3 == 3'b000));
            OP_I:    legal_c = (func_3 != 3'b001) && (func_3 != 3'b101);
            OP_LW,
            OP_SW:   legal_c = (func_3 == 3'b010);
            OP_BR:   legal_c = (func_3 != 3'b010) && (func_3 != 3'b011);
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_c = 1'b1;
            default: legal_c = 1'b0;
        endcase
    end

    // Shared func_3 decode; func_7[5] selects sub only for register-register ops.
    always_comb begin
        alu_func_c = ALU_ADD;
        case (func_3)
            3'b000:  alu_func_c = (opcode == OP_R && func_7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_func_c = ALU_SLT;
            3'b011:  alu_func_c = ALU_SLTU;
            3'b100:  alu_func_c = ALU_XOR;
            3'b110:  alu_func_c = ALU_OR;
            3'b111:  alu_func_c = ALU_AND;
            default: alu_func_c = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        retire_c     = 1'b0;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        illegal_c    = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        result_src_c = 2'b00;
        imm_src_c    = 3'b000;
        alu_ctl_c    = ALU_ADD;
        mem_done_c   = (MEM_HANDSHAKE == 0) || mem_ready;
        case (state_q)
            S_FETCH: begin
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                if (mem_done_c) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a_c   = 2'b01;
                src_b_c   = 2'b01;
                imm_src_c = (opcode == OP_JAL) ? 3'b100 : 3'b010;
                if (!legal_c) state_d = S_TRAP;
                else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECR;
                        OP_I:         state_d = S_EXECI;
                        OP_BR:        state_d = S_BRANCH;
                        OP_JAL:       state_d = S_JAL;
                        OP_JALR:      state_d = S_JALRT;
                        OP_LUI:       state_d = S_LUI;
                        default:      state_d = S_AUIPC;
                    endcase
                end
            end
            S_MEMADR: begin
                src_a_c   = 2'b10;
                src_b_c   = 2'b01;
                imm_src_c = (opcode == OP_SW) ? 3'b001 : 3'b000;
                state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (mem_done_c) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_done_c) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c   = 2'b10;
                alu_ctl_c = alu_func_c;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c   = 2'b10;
                src_b_c   = 2'b01;
                alu_ctl_c = alu_func_c;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                // Unsigned/signed compares leave a nonzero result when "less" holds.
                src_a_c    = 2'b10;
                alu_ctl_c  = func_3[2] ? (func_3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                pc_write_c = (func_3[2] ^ func_3[0]) ? ~Zero : Zero;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL, S_JALRL: begin
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALRT: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
                state_d = S_JALRL;
            end
            S_LUI, S_AUIPC: begin
                src_a_c   = (state_q == S_LUI) ? 2'b11 : 2'b01;
                src_b_c   = 2'b01;
                imm_src_c = 3'b011;
                state_d   = S_ALUWB;
            end
            S_TRAP:  illegal_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
        instret_d = retire_c ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign PCWrite    = pc_write_c  & ~rst;
    assign IRWrite    = ir_write_c  & ~rst;
    assign RegWrite   = reg_write_c & ~rst;
    assign MemWrite   = mem_write_c & ~rst;
    assign AdrSrc     = adr_src_c   & ~rst;
    assign illegal    = illegal_c   & ~rst;
    assign ALUSrcA    = rst ? 2'b00 : src_a_c;
    assign ALUSrcB    = rst ? 2'b00 : src_b_c;
    assign ResultSrc  = rst ? 2'b00 : result_src_c;
    assign ImmSrc     = rst ? 3'b000 : imm_src_c;
    assign ALUControl = rst ? 3'b000 : alu_ctl_c;
    assign instret    = rst ? '0 : instret_q;
    assign state_dbg  = rst ? 4'd0 : state_q;
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Bench for riscv_multicycle_controller: per-instruction expected control sequences
// built from the instruction-level behaviour, compared cycle by cycle.
module tb_riscv_multicycle_controller;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [6:0] opcode, func_7;
    logic [2:0] func_3;

    logic pc_w, ir_w, rg_w, mm_w, adr, ill;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm, alu;
    logic [31:0] instret;
    logic [3:0] st_dbg;

    logic pc_w0, ir_w0, rg_w0, mm_w0, adr0, ill0;
    logic [1:0] sa0, sb0, rs0;
    logic [2:0] imm0, alu0;
    logic [2:0] instret0;
    logic [3:0] st_dbg0;

    logic [17:0] vec, vec0;
    assign vec  = {pc_w, ir_w, rg_w, mm_w, adr, sa, sb, rs, imm, alu, ill};
    assign vec0 = {pc_w0, ir_w0, rg_w0, mm_w0, adr0, sa0, sb0, rs0, imm0, alu0, ill0};

    riscv_multicycle_controller #(.MEM_HANDSHAKE(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func_3(func_3), .func_7(func_7),
        .Zero(zero), .mem_ready(mem_ready),
        .PCWrite(pc_w), .IRWrite(ir_w), .RegWrite(rg_w), .MemWrite(mm_w), .AdrSrc(adr),
        .ALUSrcA(sa), .ALUSrcB(sb), .ResultSrc(rs), .ImmSrc(imm), .ALUControl(alu),
        .illegal(ill), .instret(instret), .state_dbg(st_dbg)
    );

    // Second instance: no handshake, narrow counter so wraparound is reachable.
    riscv_multicycle_controller #(.MEM_HANDSHAKE(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .func_3(func_3), .func_7(func_7),
        .Zero(zero), .mem_ready(1'b0),
        .PCWrite(pc_w0), .IRWrite(ir_w0), .RegWrite(rg_w0), .MemWrite(mm_w0), .AdrSrc(adr0),
        .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(rs0), .ImmSrc(imm0), .ALUControl(alu0),
        .illegal(ill0), .instret(instret0), .state_dbg(st_dbg0)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_cnt;
    logic [2:0]  exp_cnt0;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [17:0] st_done[$];
    logic [17:0] st_wait[$];
    bit          st_mem[$];
    logic [2:0]  alu_f3_tab [0:5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [2:0]  br_f3_tab  [0:5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    function automatic logic [17:0] mk(input logic pcw, irw, rw, mw, ad,
                                       input logic [1:0] a, b, r,
                                       input logic [2:0] im, al, input logic il);
        return {pcw, irw, rw, mw, ad, a, b, r, im, al, il};
    endfunction

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bit alu_f3_ok;
        alu_f3_ok = 1'b0;
        for (int i = 0; i < 6; i++) if (alu_f3_tab[i] == f3) alu_f3_ok = 1'b1;
        if (op == OP_R)  return alu_f3_ok && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));
        if (op == OP_I)  return alu_f3_ok;
        if (op == OP_LW || op == OP_SW) return f3 == 3'd2;
        if (op == OP_BR) return !(f3 == 3'd2 || f3 == 3'd3);
        return op == OP_JAL || op == OP_JALR || op == OP_LUI || op == OP_AUIPC;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic use_sub);
        case (f3)
            3'd0:    return use_sub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd3:    return 3'b110;
            3'd4:    return 3'b100;
            3'd6:    return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    task automatic push_step(input logic [17:0] d, input logic [17:0] w, input bit m);
        st_done.push_back(d);
        st_wait.push_back(w);
        st_mem.push_back(m);
    endtask

    // Reference: the sequence of per-cycle control vectors an instruction should produce.
    task automatic model_build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input int trap_n, output bit ok);
        logic [17:0] wb;
        logic cond, taken;
        logic [2:0] bal;
        wb = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0);
        push_step(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'd0, 3'd0, 1'b0),
                  mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'd0, 3'd0, 1'b0), 1'b1);
        ok = is_legal(op, f3, f7);
        push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00,
                     (op == OP_JAL) ? 3'd4 : 3'd2, 3'd0, 1'b0), 18'd0, 1'b0);
        if (!ok) begin
            for (int i = 0; i < trap_n; i++)
                push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b1), 18'd0, 1'b0);
        end else begin
            case (op)
                OP_LW: begin
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'd0, 3'd0, 1'b0), 18'd0, 1'b0);
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0),
                              mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0), 1'b1);
                    push_step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 1'b0), 18'd0, 1'b0);
                end
                OP_SW: begin
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'd1, 3'd0, 1'b0), 18'd0, 1'b0);
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0),
                              mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0), 1'b1);
                end
                OP_R: begin
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'd0, alu_of(f3, f7[5]), 1'b0), 18'd0, 1'b0);
                    push_step(wb, 18'd0, 1'b0);
                end
                OP_I: begin
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'd0, alu_of(f3, 1'b0), 1'b0), 18'd0, 1'b0);
                    push_step(wb, 18'd0, 1'b0);
                end
                OP_BR: begin
                    // beq/bne test equality (Zero); the rest test "less than" (result nonzero).
                    cond  = (f3 == 3'd0 || f3 == 3'd1) ? z : !z;
                    taken = (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6) ? cond : !cond;
                    bal   = (f3 == 3'd4 || f3 == 3'd5) ? 3'b101 : ((f3 == 3'd6 || f3 == 3'd7) ? 3'b110 : 3'b001);
                    push_step(mk(taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'd0, bal, 1'b0), 18'd0, 1'b0);
                end
                OP_JAL: begin
                    push_step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'd0, 3'd0, 1'b0), 18'd0, 1'b0);
                    push_step(wb, 18'd0, 1'b0);
                end
                OP_JALR: begin
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'd0, 3'd0, 1'b0), 18'd0, 1'b0);
                    push_step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'd0, 3'd0, 1'b0), 18'd0, 1'b0);
                    push_step(wb, 18'd0, 1'b0);
                end
                default: begin
                    push_step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (op == OP_LUI) ? 2'b11 : 2'b01,
                                 2'b01, 2'b00, 3'd3, 3'd0, 1'b0), 18'd0, 1'b0);
                    push_step(wb, 18'd0, 1'b0);
                end
            endcase
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        mem_ready = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_cnt = 32'd0;
        exp_cnt0 = 3'd0;
    endtask

    // Drives one instruction; wf/wm are wait cycles in fetch / data access (negative = random).
    task automatic drive_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input int wf, input int wm, input bit use0, input int trap_n);
        bit ok, m;
        logic [17:0] d, w;
        int nw, mem_idx;
        opcode = op; func_3 = f3; func_7 = f7; zero = z;
        model_build(op, f3, f7, z, trap_n, ok);
        mem_idx = 0;
        while (st_done.size() > 0) begin
            d = st_done.pop_front();
            w = st_wait.pop_front();
            m = st_mem.pop_front();
            nw = 0;
            if (m && !use0) begin
                nw = (mem_idx == 0) ? wf : wm;
                if (nw < 0) nw = $urandom_range(0, 2);
                mem_idx++;
            end
            for (int i = 0; i < nw; i++) begin
                mem_ready = 1'b0;
                @(negedge clk);
                exp_q.push_back(w);
                obs_q.push_back(vec);
                @(posedge clk);
                #1;
            end
            mem_ready = use0 ? 1'b0 : (m ? 1'b1 : 1'($urandom_range(0, 1)));
            @(negedge clk);
            exp_q.push_back(d);
            obs_q.push_back(use0 ? vec0 : vec);
            @(posedge clk);
            #1;
        end
        if (ok) begin
            exp_cnt  = exp_cnt + 32'd1;
            exp_cnt0 = exp_cnt0 + 3'd1;
        end
        if (!use0) mem_ready = 1'b1;
    endtask

    task automatic gen_legal(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
        int k;
        k  = $urandom_range(0, 8);
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom_range(0, 127));
        case (k)
            0: begin
                op = OP_R;
                f3 = alu_f3_tab[$urandom_range(0, 5)];
                f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            1: begin op = OP_I; f3 = alu_f3_tab[$urandom_range(0, 5)]; end
            2: begin op = OP_LW; f3 = 3'd2; end
            3: begin op = OP_SW; f3 = 3'd2; end
            4: begin op = OP_BR; f3 = br_f3_tab[$urandom_range(0, 5)]; end
            5: op = OP_JAL;
            6: op = OP_JALR;
            7: op = OP_LUI;
            default: op = OP_AUIPC;
        endcase
    endtask

    task automatic test_reset;
        logic [17:0] e, o;
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        opcode = OP_I; func_3 = 3'd0; func_7 = 7'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (vec !== 18'd0 || instret !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got vec=%b instret=%0d, want all zero", vec, instret);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_cnt = 32'd0;
        exp_cnt0 = 3'd0;
        drive_instr(OP_I, 3'd0, 7'd0, 1'b0, 0, 0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL addi_seq: got %b want %b", o, e); end
        end
        n_cmp++;
        if (instret !== 32'd1) begin n_bad++; $display("FAIL addi_instret: got %0d want 1", instret); end
    endtask

    task automatic test_lw_wait;
        logic [17:0] e, o;
        int n;
        n = exp_q.size();
        drive_instr(OP_LW, 3'd2, 7'd0, 1'b0, 0, 3, 1'b0, 0);
        n_cmp++;
        if (exp_q.size() - n !== 8) begin n_bad++; $display("FAIL lw_len: got %0d want 8", exp_q.size() - n); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL lw_wait_seq: got %b want %b", o, e); end
        end
        n_cmp++;
        if (instret !== exp_cnt) begin n_bad++; $display("FAIL lw_instret: got %0d want %0d", instret, exp_cnt); end
    endtask

    task automatic test_branches;
        logic [17:0] e, o;
        for (int i = 0; i < 6; i++) begin
            for (int z = 0; z < 2; z++) begin
                drive_instr(OP_BR, br_f3_tab[i], 7'd0, 1'(z), 0, 0, 1'b0, 0);
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
                    if (o !== e) begin
                        n_bad++;
                        $display("FAIL branch f3=%0d zero=%0d: got %b want %b", br_f3_tab[i], z, o, e);
                    end
                end
            end
        end
        n_cmp++;
        if (instret !== exp_cnt) begin n_bad++; $display("FAIL branch_instret: got %0d want %0d", instret, exp_cnt); end
    endtask

    task automatic test_jalr;
        logic [17:0] e, o;
        drive_instr(OP_JALR, 3'd0, 7'd0, 1'b0, 0, 0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL jalr_seq: got %b want %b", o, e); end
        end
        n_cmp++;
        if (instret !== exp_cnt) begin n_bad++; $display("FAIL jalr_instret: got %0d want %0d", instret, exp_cnt); end
    endtask

    task automatic test_random;
        logic [17:0] e, o;
        logic [6:0] op, f7;
        logic [2:0] f3;
        apply_reset(1);
        for (int i = 0; i < 40; i++) begin
            gen_legal(op, f3, f7);
            drive_instr(op, f3, f7, 1'($urandom_range(0, 1)), -1, -1, 1'b0, 0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL random op=%b f3=%0d: got %b want %b", op, f3, o, e); end
            end
            n_cmp++;
            if (instret !== exp_cnt) begin n_bad++; $display("FAIL random_instret: got %0d want %0d", instret, exp_cnt); end
        end
    endtask

    task automatic test_trap;
        logic [17:0] e, o;
        logic [6:0] bad_op  [0:8] = '{7'b0001111, OP_R, OP_R, OP_R, OP_I, OP_LW, OP_SW, OP_BR, 7'b0000000};
        logic [2:0] bad_f3  [0:8] = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd5, 3'd0, 3'd6, 3'd3, 3'd0};
        logic [6:0] bad_f7  [0:8] = '{7'h00, 7'h00, 7'h20, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        for (int i = 0; i < 9; i++) begin
            apply_reset(1);
            drive_instr(bad_op[i], bad_f3[i], bad_f7[i], 1'b0, 0, 0, 1'b0, (i == 0) ? 10 : 3);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL trap case %0d: got %b want %b", i, o, e); end
            end
            n_cmp++;
            if (instret !== 32'd0) begin n_bad++; $display("FAIL trap_instret %0d: got %0d want 0", i, instret); end
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (vec !== 18'd0) begin n_bad++; $display("FAIL trap_rst_hold: got %b want 0", vec); end
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (vec !== mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'd0, 3'd0, 1'b0)) begin
            n_bad++; $display("FAIL trap_exit_fetch: got %b", vec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        apply_reset(1);
        opcode = OP_SW; func_3 = 3'd2; func_7 = 7'd0; mem_ready = 1'b1;
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mm_w !== 1'b1) begin n_bad++; $display("FAIL sw_memwrite_held: got %b want 1", mm_w); end
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (vec !== 18'd0) begin n_bad++; $display("FAIL sw_abort_rst: got %b want 0", vec); end
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vec !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'd0, 3'd0, 1'b0) || instret !== 32'd0) begin
            n_bad++; $display("FAIL sw_abort_after: got vec=%b instret=%0d want fetch-wait, 0", vec, instret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_handshake;
        logic [17:0] e, o;
        logic [6:0] op, f7;
        logic [2:0] f3;
        apply_reset(1);
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            gen_legal(op, f3, f7);
            drive_instr(op, f3, f7, 1'($urandom_range(0, 1)), 0, 0, 1'b1, 0);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL nohs op=%b f3=%0d: got %b want %b", op, f3, o, e); end
            end
        end
        n_cmp++;
        if (instret0 !== exp_cnt0) begin n_bad++; $display("FAIL nohs_instret_wrap: got %0d want %0d", instret0, exp_cnt0); end
        @(negedge clk);
        n_cmp++;
        if (vec !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'd0, 3'd0, 1'b0) || instret !== 32'd0) begin
            n_bad++; $display("FAIL fetch_stall: got vec=%b instret=%0d", vec, instret);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw_wait();
        test_branches();
        test_jalr();
        test_random();
        test_trap();
        test_reset_abort();
        test_no_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
